// File: rtl/mc_cpu_pkg.sv
// Shared encodings, state/opcode enums and flag helpers for the multi-cycle
// AArch64-subset core.
package mc_cpu_pkg;

  typedef enum logic [1:0] {ST_FETCH, ST_DECODE, ST_EXEC, ST_HALT} state_t;

  typedef enum logic [3:0] {
    OP_ILL, OP_MOVZ, OP_ADDI, OP_SUBI, OP_SUBS,
    OP_CBZ, OP_CBNZ, OP_B, OP_BCOND, OP_HLT
  } op_t;

  localparam logic [4:0] REG_SP = 5'd31;

  localparam logic [31:0] MOVZ_MASK  = 32'hFF80_0000, MOVZ_MATCH  = 32'hD280_0000;
  localparam logic [31:0] ADDI_MASK  = 32'hFF80_0000, ADDI_MATCH  = 32'h9100_0000;
  localparam logic [31:0] SUBI_MASK  = 32'hFF80_0000, SUBI_MATCH  = 32'hD100_0000;
  localparam logic [31:0] SUBS_MASK  = 32'hFFE0_FC00, SUBS_MATCH  = 32'hEB00_0000;
  localparam logic [31:0] CBZ_MASK   = 32'hFF00_0000, CBZ_MATCH   = 32'hB400_0000;
  localparam logic [31:0] CBNZ_MASK  = 32'hFF00_0000, CBNZ_MATCH  = 32'hB500_0000;
  localparam logic [31:0] B_MASK     = 32'hFC00_0000, B_MATCH     = 32'h1400_0000;
  localparam logic [31:0] BCOND_MASK = 32'hFF00_0010, BCOND_MATCH = 32'h5400_0000;
  localparam logic [31:0] HLT_MASK   = 32'hFFE0_001F, HLT_MATCH   = 32'hD440_0000;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_AL = 4'hE;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic cond_known(input logic [3:0] cond);
    return cond inside {COND_EQ, COND_NE, COND_GE, COND_LT, COND_AL};
  endfunction

  function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] nzcv);
    logic holds;
    holds = 1'b0;
    case (cond)
      COND_EQ: holds = nzcv[FLAG_Z];
      COND_NE: holds = !nzcv[FLAG_Z];
      COND_GE: holds = (nzcv[FLAG_N] == nzcv[FLAG_V]);
      COND_LT: holds = (nzcv[FLAG_N] != nzcv[FLAG_V]);
      COND_AL: holds = 1'b1;
      default: holds = 1'b0;
    endcase
    return holds;
  endfunction

  // Narrow datapaths cannot hold a MOVZ shifted by 32 or 48.
  function automatic op_t decode_op(input logic [31:0] ir, input logic xlen32);
    op_t op;
    op = OP_ILL;
    if ((ir & MOVZ_MASK) == MOVZ_MATCH)        op = (xlen32 && ir[22]) ? OP_ILL : OP_MOVZ;
    else if ((ir & ADDI_MASK) == ADDI_MATCH)   op = OP_ADDI;
    else if ((ir & SUBI_MASK) == SUBI_MATCH)   op = OP_SUBI;
    else if ((ir & SUBS_MASK) == SUBS_MATCH)   op = OP_SUBS;
    else if ((ir & CBZ_MASK) == CBZ_MATCH)     op = OP_CBZ;
    else if ((ir & CBNZ_MASK) == CBNZ_MATCH)   op = OP_CBNZ;
    else if ((ir & B_MASK) == B_MATCH)         op = OP_B;
    else if ((ir & BCOND_MASK) == BCOND_MATCH) op = cond_known(ir[3:0]) ? OP_BCOND : OP_ILL;
    else if ((ir & HLT_MASK) == HLT_MATCH)     op = OP_HLT;
    return op;
  endfunction

endpackage

// File: rtl/mc_regfile.sv
// X0-X30 plus SP; register 31 resolves to SP or XZR per port via sp_sel.
module mc_regfile
  import mc_cpu_pkg::*;
#(
  parameter int               XLEN   = 64,
  parameter logic [XLEN-1:0]  INITSP = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [4:0]      ra1,
  input  logic            sp1,
  output logic [XLEN-1:0] rd1,
  input  logic [4:0]      ra2,
  input  logic            sp2,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [4:0]      wa,
  input  logic            wsp,
  input  logic [XLEN-1:0] wd
);

  logic [XLEN-1:0] regs [31];
  logic [XLEN-1:0] sp;

  assign rd1 = (ra1 == REG_SP) ? (sp1 ? sp : '0) : regs[ra1];
  assign rd2 = (ra2 == REG_SP) ? (sp2 ? sp : '0) : regs[ra2];

  // NOTE: this array is reset on purpose: architectural registers must read
  // zero after reset, so it maps to flops rather than a RAM macro.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 31; i++) regs[i] <= '0;
      sp <= INITSP;
    end else if (we) begin
      if (wa != REG_SP) regs[wa] <= wd;
      else if (wsp)     sp <= wd;
    end
  end

endmodule

// File: rtl/mc_cpu.sv
// Multi-cycle AArch64-subset core: FETCH/DECODE/EXEC/HALT with a req/ready
// instruction fetch port and an NZCV flag register.
module mc_cpu
  import mc_cpu_pkg::*;
#(
  parameter int              XLEN   = 64,
  parameter int              PC_W   = 64,
  parameter logic [PC_W-1:0] INITPC = '0,
  parameter logic [XLEN-1:0] INITSP = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic [PC_W-1:0] pc,
  output logic            retire,
  output logic            halted,
  output logic            illegal
);

  state_t          state;
  op_t             op_q;
  logic [31:0]     ir;
  logic [XLEN-1:0] a_q, b_q;
  logic [3:0]      nzcv;

  // Gated by reset so the request is low in reset yet present in the very
  // first cycle afterwards.
  assign imem_req  = reset_n && (state == ST_FETCH);
  assign imem_addr = pc;

  op_t             dec_op;
  logic [4:0]      rd, rn, rm, ra1;
  logic            sp1;
  logic [XLEN-1:0] rd1, rd2, dec_b;
  logic [63:0]     movz_imm, arith_imm;

  assign rd     = ir[4:0];
  assign rn     = ir[9:5];
  assign rm     = ir[20:16];
  assign dec_op = decode_op(ir, XLEN == 32);
  assign ra1    = (dec_op == OP_CBZ || dec_op == OP_CBNZ) ? rd : rn;
  assign sp1    = (dec_op == OP_ADDI || dec_op == OP_SUBI);

  assign movz_imm  = {48'd0, ir[20:5]} << {ir[22:21], 4'b0000};
  assign arith_imm = ir[22] ? {40'd0, ir[21:10], 12'd0} : {52'd0, ir[21:10]};

  always_comb begin
    dec_b = rd2;
    case (dec_op)
      OP_MOVZ:          dec_b = movz_imm[XLEN-1:0];
      OP_ADDI, OP_SUBI: dec_b = arith_imm[XLEN-1:0];
      default:          dec_b = rd2;
    endcase
  end

  logic [XLEN-1:0] diff, alu_res;
  logic [3:0]      subs_flags;
  logic            we, wsp;

  assign diff = a_q - b_q;

  always_comb begin
    case (op_q)
      OP_ADDI:          alu_res = a_q + b_q;
      OP_SUBI, OP_SUBS: alu_res = diff;
      default:          alu_res = b_q;
    endcase
  end

  assign subs_flags[FLAG_N] = diff[XLEN-1];
  assign subs_flags[FLAG_Z] = (diff == '0);
  assign subs_flags[FLAG_C] = (a_q >= b_q);
  assign subs_flags[FLAG_V] = (a_q[XLEN-1] != b_q[XLEN-1]) && (diff[XLEN-1] != a_q[XLEN-1]);

  assign we  = (state == ST_EXEC) && (op_q inside {OP_MOVZ, OP_ADDI, OP_SUBI, OP_SUBS});
  assign wsp = (op_q == OP_ADDI) || (op_q == OP_SUBI);

  mc_regfile #(.XLEN(XLEN), .INITSP(INITSP)) u_rf (
    .clk     (clk),
    .reset_n (reset_n),
    .ra1     (ra1),
    .sp1     (sp1),
    .rd1     (rd1),
    .ra2     (rm),
    .sp2     (1'b0),
    .rd2     (rd2),
    .we      (we),
    .wa      (rd),
    .wsp     (wsp),
    .wd      (alu_res)
  );

  logic [PC_W-1:0] off26, off19, offset, next_pc;
  logic            taken;

  assign off26 = {{(PC_W-28){ir[25]}}, ir[25:0], 2'b00};
  assign off19 = {{(PC_W-21){ir[23]}}, ir[23:5], 2'b00};

  always_comb begin
    taken  = 1'b0;
    offset = off19;
    case (op_q)
      OP_B:     begin taken = 1'b1; offset = off26; end
      OP_CBZ:   taken = (a_q == '0);
      OP_CBNZ:  taken = (a_q != '0);
      OP_BCOND: taken = cond_holds(ir[3:0], nzcv);
      default:  taken = 1'b0;
    endcase
    next_pc = taken ? pc + offset : pc + PC_W'(3'd4);
  end

  // NOTE: every state element here uses non-blocking assignment so all
  // updates of one edge see the values from before that edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_FETCH;
      pc      <= INITPC;
      ir      <= '0;
      op_q    <= OP_ILL;
      a_q     <= '0;
      b_q     <= '0;
      nzcv    <= '0;
      retire  <= 1'b0;
      halted  <= 1'b0;
      illegal <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (imem_ready) begin
            ir    <= imem_rdata;
            state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          op_q   <= dec_op;
          a_q    <= rd1;
          b_q    <= dec_b;
          retire <= (dec_op != OP_ILL);
          state  <= ST_EXEC;
        end
        ST_EXEC: begin
          retire <= 1'b0;
          if (op_q == OP_SUBS) nzcv <= subs_flags;
          case (op_q)
            OP_ILL: begin
              illegal <= 1'b1;
              halted  <= 1'b1;
              state   <= ST_HALT;
            end
            OP_HLT: begin
              halted <= 1'b1;
              state  <= ST_HALT;
            end
            default: begin
              pc    <= next_pc;
              state <= ST_FETCH;
            end
          endcase
        end
        default: state <= ST_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_cpu.sv
// Bench for mc_cpu: three instances (64-bit, 32-bit, wrapping INITPC) run in
// turn; a queue of expected fetch addresses/flags is compared at each fetch.
`timescale 1ns/1ps
module tb_mc_cpu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]        rst_v;
  logic [2:0]        req_v, retire_v, halted_v, illegal_v;
  logic [2:0][63:0]  addr_v, pc_v;
  logic [2:0][31:0]  rdata_v;
  logic [2:0][3:0]   nzcv_v;
  logic [63:0]       x1_64;
  logic [31:0]       x4_32;
  logic              ready;
  logic [31:0]       mem [256];

  int sel = 0;
  int stall = 0;
  int wait_cnt = 0;

  assign ready = req_v[sel] ? (wait_cnt >= stall) : 1'b1;
  always @(posedge clk) begin
    if (req_v[sel] && !ready) wait_cnt <= wait_cnt + 1;
    else                      wait_cnt <= 0;
  end

  assign rdata_v[0] = mem[addr_v[0][9:2]];
  assign rdata_v[1] = mem[addr_v[1][9:2]];
  assign rdata_v[2] = mem[addr_v[2][9:2]];

  mc_cpu #(.XLEN(64), .PC_W(64), .INITPC(64'd0), .INITSP(64'd0)) dut64 (
    .clk(clk), .reset_n(rst_v[0]), .imem_req(req_v[0]), .imem_addr(addr_v[0]),
    .imem_ready(ready), .imem_rdata(rdata_v[0]), .pc(pc_v[0]),
    .retire(retire_v[0]), .halted(halted_v[0]), .illegal(illegal_v[0]));

  mc_cpu #(.XLEN(32), .PC_W(64), .INITPC(64'd0), .INITSP(32'd0)) dut32 (
    .clk(clk), .reset_n(rst_v[1]), .imem_req(req_v[1]), .imem_addr(addr_v[1]),
    .imem_ready(ready), .imem_rdata(rdata_v[1]), .pc(pc_v[1]),
    .retire(retire_v[1]), .halted(halted_v[1]), .illegal(illegal_v[1]));

  mc_cpu #(.XLEN(64), .PC_W(64), .INITPC(64'hFFFF_FFFF_FFFF_FFFC), .INITSP(64'd0)) dutw (
    .clk(clk), .reset_n(rst_v[2]), .imem_req(req_v[2]), .imem_addr(addr_v[2]),
    .imem_ready(ready), .imem_rdata(rdata_v[2]), .pc(pc_v[2]),
    .retire(retire_v[2]), .halted(halted_v[2]), .illegal(illegal_v[2]));

  assign nzcv_v[0] = dut64.nzcv;
  assign nzcv_v[1] = dut32.nzcv;
  assign nzcv_v[2] = dutw.nzcv;
  assign x1_64     = dut64.u_rf.regs[1];
  assign x4_32     = dut32.u_rf.regs[4];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [63:0] addr;
    logic [3:0]  nzcv;
  } fetch_t;

  fetch_t      exp_q[$];
  int          cyc = 0;
  int          retire_cnt = 0;
  int          last_ret = -1;
  int          exp_gap = 3;
  logic        mon_en = 1'b0;
  logic        stall_seen = 1'b0;
  logic [63:0] stall_addr = '0;

  task automatic push(input logic [63:0] a, input logic [3:0] f);
    fetch_t e;
    e.addr = a;
    e.nzcv = f;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: samples on the falling edge.
  initial forever begin
    fetch_t e;
    @(negedge clk);
    cyc++;
    if (mon_en && rst_v[sel]) begin
      if (req_v[sel]) begin
        if (stall_seen) check("stall_addr", addr_v[sel], stall_addr);
        if (ready) begin
          stall_seen = 1'b0;
          if (exp_q.size() == 0) begin
            check("fetch_extra", 64'(exp_q.size()), 64'd1);
          end else begin
            e = exp_q.pop_front();
            check("fetch_addr", addr_v[sel], e.addr);
            check("fetch_nzcv", 64'(nzcv_v[sel]), 64'(e.nzcv));
          end
        end else if (!stall_seen) begin
          stall_seen = 1'b1;
          stall_addr = addr_v[sel];
        end
      end
      if (retire_v[sel]) begin
        if (last_ret >= 0) check("retire_gap", 64'(cyc - last_ret), 64'(exp_gap));
        last_ret = cyc;
        retire_cnt++;
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    exp_q.delete();
  endtask

  task automatic load_loop();
    clear_mem();
    mem[0] = 32'hD28000A1;  // MOVZ X1,#5
    mem[1] = 32'hD1000421;  // SUB  X1,X1,#1
    mem[2] = 32'hB5FFFFE1;  // CBNZ X1,-4
    mem[3] = 32'hD4400000;  // HLT
    push(64'd0, 4'h0);
    for (int i = 0; i < 5; i++) begin
      push(64'd4, 4'h0);
      push(64'd8, 4'h0);
    end
    push(64'd12, 4'h0);
  endtask

  task automatic start(input int s, input int st, input int gap, input logic [63:0] init_pc);
    sel        = s;
    stall      = st;
    exp_gap    = gap;
    retire_cnt = 0;
    last_ret   = -1;
    stall_seen = 1'b0;
    mon_en     = 1'b1;
    @(posedge clk);
    #1;
    check("rst_req",     64'(req_v[s]),     64'd0);
    check("rst_retire",  64'(retire_v[s]),  64'd0);
    check("rst_halted",  64'(halted_v[s]),  64'd0);
    check("rst_illegal", 64'(illegal_v[s]), 64'd0);
    check("rst_pc",      pc_v[s],           init_pc);
    rst_v[s] = 1'b1;
    #1;
    check("req_first", 64'(req_v[s]), 64'd1);
  endtask

  task automatic wait_halt(input int s);
    int n;
    n = 0;
    while (!halted_v[s] && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("halt_in_time", 64'(halted_v[s]), 64'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic finish_run(input int s);
    check("fetch_left", 64'(exp_q.size()), 64'd0);
    rst_v[s] = 1'b0;
    mon_en   = 1'b0;
    exp_q.delete();
  endtask

  task automatic loop_final(input string tag);
    check({tag, "_retires"}, 64'(retire_cnt),   64'd12);
    check({tag, "_x1"},      x1_64,             64'd0);
    check({tag, "_halted"},  64'(halted_v[0]),  64'd1);
    check({tag, "_illegal"}, 64'(illegal_v[0]), 64'd0);
    check({tag, "_pc"},      pc_v[0],           64'd12);
  endtask

  initial begin
    int n;
    rst_v = 3'b000;
    clear_mem();
    repeat (2) @(posedge clk);

    // Countdown loop, ready always high.
    load_loop();
    start(0, 0, 3, 64'd0);
    wait_halt(0);
    loop_final("loop");
    finish_run(0);

    // Same loop with three stall cycles on each fetch.
    load_loop();
    start(0, 3, 6, 64'd0);
    wait_halt(0);
    loop_final("stall");
    finish_run(0);

    // CMP with less-than, then equal operands.
    clear_mem();
    mem[0]  = 32'hD2800022;  // MOVZ X2,#1
    mem[1]  = 32'hD2800043;  // MOVZ X3,#2
    mem[2]  = 32'hEB03005F;  // CMP  X2,X3
    mem[3]  = 32'h5400004B;  // B.LT +8
    mem[4]  = 32'hD4400000;  // HLT (wrong path)
    mem[5]  = 32'h5400004A;  // B.GE +8
    mem[6]  = 32'hD2800023;  // MOVZ X3,#1
    mem[7]  = 32'hEB03005F;  // CMP  X2,X3
    mem[8]  = 32'h54000040;  // B.EQ +8
    mem[9]  = 32'hD4400000;  // HLT (wrong path)
    mem[10] = 32'hD4400000;  // HLT
    push(64'd0, 4'b0000);  push(64'd4, 4'b0000);  push(64'd8, 4'b0000);
    push(64'd12, 4'b1000); push(64'd20, 4'b1000); push(64'd24, 4'b1000);
    push(64'd28, 4'b1000); push(64'd32, 4'b0110); push(64'd40, 4'b0110);
    start(0, 0, 3, 64'd0);
    wait_halt(0);
    check("cmp_retires", 64'(retire_cnt),  64'd9);
    check("cmp_nzcv",    64'(nzcv_v[0]),   64'b0110);
    check("cmp_pc",      pc_v[0],          64'd40);
    finish_run(0);

    // Reset asserted while the first MOVZ is in EXEC.
    load_loop();
    start(0, 0, 3, 64'd0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!retire_v[0] && n < 20);
    check("abort_reached_exec", 64'(retire_v[0]), 64'd1);
    rst_v[0] = 1'b0;
    mon_en   = 1'b0;
    #1;
    check("abort_retire", 64'(retire_v[0]), 64'd0);
    check("abort_pc",     pc_v[0],          64'd0);
    @(negedge clk);
    check("abort_x1",     x1_64,            64'd0);
    check("abort_pc_hold", pc_v[0],         64'd0);
    exp_q.delete();

    // 32-bit datapath: wrap to zero, then MOVZ hw=2 is illegal.
    clear_mem();
    mem[0] = 32'hD1000484;  // SUB  X4,X4,#1
    mem[1] = 32'h91000484;  // ADD  X4,X4,#1
    mem[2] = 32'hB5000044;  // CBNZ X4,+8
    mem[3] = 32'hD2C00005;  // MOVZ X5,#0,LSL#32
    mem[4] = 32'hD4400000;  // HLT
    push(64'd0, 4'h0); push(64'd4, 4'h0); push(64'd8, 4'h0); push(64'd12, 4'h0);
    start(1, 0, 3, 64'd0);
    wait_halt(1);
    check("x32_x4",      64'(x4_32),        64'd0);
    check("x32_retires", 64'(retire_cnt),   64'd3);
    check("x32_illegal", 64'(illegal_v[1]), 64'd1);
    check("x32_pc",      pc_v[1],           64'd12);
    finish_run(1);

    // PC wrap from the top of the address space.
    clear_mem();
    mem[255] = 32'h14000002;  // B +8
    mem[1]   = 32'hD4400000;  // HLT
    push(64'hFFFF_FFFF_FFFF_FFFC, 4'h0);
    push(64'd4, 4'h0);
    start(2, 0, 3, 64'hFFFF_FFFF_FFFF_FFFC);
    wait_halt(2);
    check("wrap_pc",      pc_v[2],           64'd4);
    check("wrap_retires", 64'(retire_cnt),   64'd2);
    check("wrap_illegal", 64'(illegal_v[2]), 64'd0);
    finish_run(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mc_cpu.md
# mc_cpu

Multi-cycle, parametrised successor to the single-cycle AArch64-subset core. It fetches through a req/ready instruction-memory handshake, then executes a small integer subset through a FETCH/DECODE/EXEC state machine. It keeps an NZCV flag register and stops on HLT or on an undecodable word. It sits between the testbench/SoC instruction memory and the debug/halt logic, and replaces the combinational-fetch top level.

## Interface
Parameters:
- XLEN, 64, datapath and register width; legal values 32 or 64.
- PC_W, 64, program-counter width.
- INITPC, 0, PC value loaded at reset.
- INITSP, 0, SP value loaded at reset.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request; high only in FETCH.
- imem_addr  out  PC_W  fetch address; equals pc while imem_req is high.
- imem_ready  in  1  memory accepts the request; data is valid in the same cycle.
- imem_rdata  in  32  instruction word; sampled on the edge where imem_req && imem_ready.
- pc  out  PC_W  architectural PC.
- retire  out  1  one-cycle pulse per retired instruction.
- halted  out  1  sticky; set on HLT or on an illegal instruction.
- illegal  out  1  sticky; set only for an undecodable instruction.

## Operation
- Supported instructions:
  - MOVZ with hw shift; for XLEN=32, hw[1]=1 is illegal.
  - ADD (imm) and SUB (imm), 64-bit form, with sh=1 meaning imm12<<12.
  - SUBS (shifted register, shift=0); CMP is the Rd=31 alias.
  - CBZ and CBNZ.
  - B.
  - B.cond for EQ, NE, LT, GE, AL; any other cond is illegal.
  - HLT: bits[31:21]=11010100010 and bits[4:0]=0.
- Any other encoding: set illegal and halted. No register, flag or pc update.
- Register 31:
  - Acts as SP for Rn and Rd of ADD/SUB (imm).
  - Acts as XZR everywhere else: reads 0, writes discarded.
- Arithmetic:
  - All arithmetic is modulo 2^XLEN.
  - Immediates are zero-extended to XLEN.
- SUBS flags:
  - N = result[XLEN-1].
  - Z = (result == 0).
  - C = (Rn >= Rm), unsigned.
  - V = signed overflow of Rn − Rm.
- Branch offsets:
  - imm26<<2 (B) and imm19<<2 (CBZ/CBNZ/B.cond), sign-extended to PC_W.
  - Target = pc + offset, modulo 2^PC_W.
  - Not-taken and non-branch next PC = pc + 4, wrapping at 2^PC_W.
- Conditions:
  - LT = N≠V; GE = N==V.
  - B.cond reads the flags as committed before this instruction.

State machine:
- FETCH: imem_req=1 and imem_addr=pc. Stay in FETCH while ready=0. On req&&ready, latch IR and go to DECODE.
- DECODE: decode IR. Latch operand A (Rn/Rt) and operand B (Rm or immediate) from the register file. Go to EXEC.
- EXEC: ALU operation, then register write, flag write (SUBS only), pc update and retire=1, all on the same edge. Next state is FETCH, or HALT for HLT or illegal.
- HALT: terminal. imem_req=0 and pc frozen. Only reset leaves HALT.

## Timing
- Reset values (asynchronous assert):
  - State FETCH.
  - pc=INITPC.
  - X0–X30 = 0, SP = INITSP, NZCV = 0000.
  - imem_req = 0, retire = 0, halted = 0, illegal = 0.
- After reset_n deasserts, imem_req rises in the first cycle.
- Minimum of 3 cycles per instruction (ready high in the first FETCH cycle). Each cycle that ready stays low adds one cycle.
- retire is asserted in the EXEC cycle; the new pc is visible the following cycle.
- imem_addr holds stable while req=1 and ready=0. imem_ready is ignored when req=0.
- reset_n asserted mid-instruction aborts it: no partial write, and the instruction does not retire.
- For HLT, retire pulses, pc stays at the HLT address, and halted rises the next cycle.
- For an illegal instruction, retire is not asserted.

## Structure
- Package mc_cpu_pkg holds:
  - Opcode/mask constants for every supported encoding.
  - State enum (FETCH, DECODE, EXEC, HALT).
  - Condition-code constants.
  - Flag-index constants.
- Sub-module mc_regfile holds 31×XLEN general registers plus SP. It has two combinational read ports, one write port, XZR/SP selection by a per-port sp_sel input, and asynchronous active-low reset.
- Decode, ALU and next-PC logic live in mc_cpu.

## Test plan
- MOVZ X1,#5; SUB X1,X1,#1; CBNZ X1,−4; HLT, with ready always high:
  - Loop runs 5 times.
  - 12 retire pulses.
  - X1=0 and halted=1.
  - pc holds the HLT address.
- Fetch stall: ready low for 3 cycles on every fetch:
  - Each instruction takes 6 cycles.
  - imem_addr is stable during each stall.
  - Final state matches the no-stall run.
- CMP X2,X3 with X2=1, X3=2:
  - NZCV=1000.
  - B.LT taken and B.GE not taken.
  - With X2=X3, NZCV=0110 and B.EQ taken.
- XLEN=32: ADD X4,X4,#1 from 0xFFFFFFFF gives 0.
- XLEN=32: MOVZ with hw=2 gives illegal=1, halted=1, no retire.
- Reset and wrap:
  - With INITPC=2^PC_W−4, B +8 lands at pc=4.
  - reset_n low during EXEC leaves no register write, and pc returns to INITPC.
